// File: rtl/bus_codes_pkg.sv
// Destination/source code map for the 16-bit internal bus. The bus source
// selector uses the same map. Also holds the default data width and the
// one-hot load-vector bit positions.
package bus_codes_pkg;

   localparam int DEFAULT_WIDTH = 16;
   localparam int NUM_REGS      = 10;

   localparam logic [3:0] CODE_RA = 4'b0000;
   localparam logic [3:0] CODE_RB = 4'b0001;
   localparam logic [3:0] CODE_RC = 4'b0010;
   localparam logic [3:0] CODE_R1 = 4'b0011;
   localparam logic [3:0] CODE_R2 = 4'b0100;
   localparam logic [3:0] CODE_R3 = 4'b0101;
   localparam logic [3:0] CODE_DR = 4'b0110;
   localparam logic [3:0] CODE_AR = 4'b0111;
   localparam logic [3:0] CODE_AC = 4'b1001;
   localparam logic [3:0] CODE_PC = 4'b1010;

   // Bit positions in the one-hot load vector. The eight codes 0000-0111
   // map straight onto bits 0-7. AC and PC take the two top bits.
   localparam int IDX_RA = 0;
   localparam int IDX_RB = 1;
   localparam int IDX_RC = 2;
   localparam int IDX_R1 = 3;
   localparam int IDX_R2 = 4;
   localparam int IDX_R3 = 5;
   localparam int IDX_DR = 6;
   localparam int IDX_AR = 7;
   localparam int IDX_AC = 8;
   localparam int IDX_PC = 9;

   function automatic logic is_legal_code(input logic [3:0] code);
      return (code[3] == 1'b0) || (code == CODE_AC) || (code == CODE_PC);
   endfunction

endpackage

// File: rtl/bus_dest_regs_dest_decoder.sv
// Destination decoder: turns wr_sel/wr_en into a one-hot register load
// vector and a legal-code flag. Purely combinational.
import bus_codes_pkg::*;

module dest_decoder (
   input  logic                wr_en,
   input  logic [3:0]          wr_sel,
   output logic [NUM_REGS-1:0] load,
   output logic                legal
);

   // One-hot decode; illegal codes leave every enable low
   always_comb begin
      load  = '0;
      legal = is_legal_code(wr_sel);
      if (wr_en) begin
         case (wr_sel)
            CODE_RA: load[IDX_RA] = 1'b1;
            CODE_RB: load[IDX_RB] = 1'b1;
            CODE_RC: load[IDX_RC] = 1'b1;
            CODE_R1: load[IDX_R1] = 1'b1;
            CODE_R2: load[IDX_R2] = 1'b1;
            CODE_R3: load[IDX_R3] = 1'b1;
            CODE_DR: load[IDX_DR] = 1'b1;
            CODE_AR: load[IDX_AR] = 1'b1;
            CODE_AC: load[IDX_AC] = 1'b1;
            CODE_PC: load[IDX_PC] = 1'b1;
            default: load = '0;
         endcase
      end
   end

endmodule

// File: rtl/bus_dest_regs.sv
// Write side of the internal bus: the architectural register file.
// - Latches bus_in into the register that wr_sel decodes to.
// - Runs the in-place PC/AR increment and the AC clear.
// - A direct bus load takes priority over these micro-operations.
// Optional macro DEST_ERR_CHECK_EN adds a sticky illegal-destination flag.
// Without it, dest_err is tied to 0.
import bus_codes_pkg::*;

module bus_dest_regs #(
   parameter int WIDTH = DEFAULT_WIDTH
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] bus_in,
   input  logic             wr_en,
   input  logic [3:0]       wr_sel,
   input  logic             inc_pc,
   input  logic             inc_ar,
   input  logic             clr_ac,
   output logic [WIDTH-1:0] ar,
   output logic [WIDTH-1:0] dr,
   output logic [WIDTH-1:0] r1,
   output logic [WIDTH-1:0] r2,
   output logic [WIDTH-1:0] r3,
   output logic [WIDTH-1:0] ra,
   output logic [WIDTH-1:0] rb,
   output logic [WIDTH-1:0] rc,
   output logic [WIDTH-1:0] ac,
   output logic [WIDTH-1:0] pc,
   output logic             wr_done,
   output logic             dest_err
);

   logic [NUM_REGS-1:0] load;
   logic                legal;

   dest_decoder u_dest_decoder (
      .wr_en  (wr_en),
      .wr_sel (wr_sel),
      .load   (load),
      .legal  (legal)
   );

   // Register file with per-register priority: bus load, then micro-op, then hold
   always_ff @(posedge clk) begin
      if (reset) begin
         ra <= '0;
         rb <= '0;
         rc <= '0;
         r1 <= '0;
         r2 <= '0;
         r3 <= '0;
         dr <= '0;
         ar <= '0;
         ac <= '0;
         pc <= '0;
      end else begin
         if (load[IDX_RA]) ra <= bus_in;
         if (load[IDX_RB]) rb <= bus_in;
         if (load[IDX_RC]) rc <= bus_in;
         if (load[IDX_R1]) r1 <= bus_in;
         if (load[IDX_R2]) r2 <= bus_in;
         if (load[IDX_R3]) r3 <= bus_in;
         if (load[IDX_DR]) dr <= bus_in;

         if (load[IDX_AR])  ar <= bus_in;
         else if (inc_ar)   ar <= ar + WIDTH'(1);

         if (load[IDX_AC])  ac <= '0 | bus_in;
         else if (clr_ac)   ac <= '0;

         if (load[IDX_PC])  pc <= bus_in;
         else if (inc_pc)   pc <= pc + WIDTH'(1);
      end
   end

   // Write acknowledge: one cycle after an accepted legal write
   always_ff @(posedge clk) begin
      if (reset) wr_done <= 1'b0;
      else       wr_done <= wr_en & legal;
   end

`ifdef DEST_ERR_CHECK_EN
   logic dest_err_q;

   // Sticky illegal-destination flag, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset)                 dest_err_q <= 1'b0;
      else if (wr_en && !legal)  dest_err_q <= 1'b1;
   end

   assign dest_err = dest_err_q;
`else
   assign dest_err = 1'b0;
`endif

endmodule

// File: tb/tb_bus_dest_regs.sv
// Self-checking bench for bus_dest_regs: directed scenarios with literal
// expectations plus a randomized run against a behavioural register model.
module tb_bus_dest_regs;

`ifdef DEST_ERR_CHECK_EN
   localparam bit ERR_EN = 1'b1;
`else
   localparam bit ERR_EN = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [15:0] bus_in = '0;
   logic        wr_en = 1'b0;
   logic [3:0]  wr_sel = '0;
   logic        inc_pc = 1'b0, inc_ar = 1'b0, clr_ac = 1'b0;
   logic [15:0] ar, dr, r1, r2, r3, ra, rb, rc, ac, pc;
   logic        wr_done, dest_err;

   int checks = 0;
   int failures = 0;
   bit chk_en = 1'b0;

   always #5 clk = ~clk;

   bus_dest_regs dut (
      .clk(clk), .reset(reset), .bus_in(bus_in), .wr_en(wr_en), .wr_sel(wr_sel),
      .inc_pc(inc_pc), .inc_ar(inc_ar), .clr_ac(clr_ac),
      .ar(ar), .dr(dr), .r1(r1), .r2(r2), .r3(r3),
      .ra(ra), .rb(rb), .rc(rc), .ac(ac), .pc(pc),
      .wr_done(wr_done), .dest_err(dest_err)
   );

   // DUT registers in the model's slot order: RA RB RC R1 R2 R3 DR AR AC PC
   logic [15:0] dutv [10];
   assign dutv[0] = ra; assign dutv[1] = rb; assign dutv[2] = rc;
   assign dutv[3] = r1; assign dutv[4] = r2; assign dutv[5] = r3;
   assign dutv[6] = dr; assign dutv[7] = ar; assign dutv[8] = ac;
   assign dutv[9] = pc;

   string names [10] = '{"ra", "rb", "rc", "r1", "r2", "r3", "dr", "ar", "ac", "pc"};

   // Behavioural model
   logic [15:0] m_reg [10];
   logic        m_done = 1'b0;
   logic        m_err  = 1'b0;

   // Destination code to model slot; -1 means the code selects no register
   function automatic int slot_of(input logic [3:0] code);
      case (code)
         4'b0000: return 0;
         4'b0001: return 1;
         4'b0010: return 2;
         4'b0011: return 3;
         4'b0100: return 4;
         4'b0101: return 5;
         4'b0110: return 6;
         4'b0111: return 7;
         4'b1001: return 8;
         4'b1010: return 9;
         default: return -1;
      endcase
   endfunction

   initial for (int i = 0; i < 10; i++) m_reg[i] = '0;

   always @(posedge clk) begin
      int s;
      if (reset) begin
         for (int i = 0; i < 10; i++) m_reg[i] = '0;
         m_done = 1'b0;
         m_err  = 1'b0;
      end else begin
         s = wr_en ? slot_of(wr_sel) : -1;
         if (s != 9 && inc_pc) m_reg[9] = 16'((int'(m_reg[9]) + 1) % 65536);
         if (s != 7 && inc_ar) m_reg[7] = 16'((int'(m_reg[7]) + 1) % 65536);
         if (s != 8 && clr_ac) m_reg[8] = 16'h0000;
         if (s >= 0) m_reg[s] = bus_in;
         m_done = (s >= 0);
         if (ERR_EN && wr_en && slot_of(wr_sel) < 0) m_err = 1'b1;
      end
   end

   task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s got=%h exp=%h t=%0t", nm, act, exp, $time);
      end
   endtask

   // Compare process: every cycle once reset has been applied
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 10; i++) check({"model_", names[i]}, dutv[i], m_reg[i]);
         check("model_wr_done", {15'b0, wr_done}, {15'b0, m_done});
         check("model_dest_err", {15'b0, dest_err}, {15'b0, m_err});
      end
   end

   task automatic cyc();
      @(posedge clk);
      #1;
   endtask

   task automatic idle();
      reset = 1'b0; wr_en = 1'b0; inc_pc = 1'b0; inc_ar = 1'b0; clr_ac = 1'b0;
   endtask

   task automatic wr(input logic [3:0] sel, input logic [15:0] d);
      wr_en = 1'b1; wr_sel = sel; bus_in = d;
   endtask

   initial begin
      cyc();
      chk_en = 1'b1;
      check("reset_pc", pc, 16'h0000);
      check("reset_ra", ra, 16'h0000);
      check("reset_wr_done", {15'b0, wr_done}, 16'h0000);

      // Write R2, then confirm the one-cycle wr_done pulse
      idle(); wr(4'b0100, 16'h1234);
      cyc();
      check("r2_write", r2, 16'h1234);
      check("r2_wr_done", {15'b0, wr_done}, 16'h0001);
      check("r2_others_r1", r1, 16'h0000);
      check("r2_others_ac", ac, 16'h0000);
      idle();
      cyc();
      check("wr_done_pulse_end", {15'b0, wr_done}, 16'h0000);

      // PC wrap, then load beats increment
      wr(4'b1010, 16'hFFFF); cyc();
      idle(); inc_pc = 1'b1; cyc();
      check("pc_wrap", pc, 16'h0000);
      wr(4'b1010, 16'h0040); inc_pc = 1'b1; cyc();
      check("pc_load_wins", pc, 16'h0040);

      // AC: load beats clear, then clear alone
      idle(); wr(4'b1001, 16'h00AA); cyc();
      clr_ac = 1'b1; wr(4'b1001, 16'h5555); cyc();
      check("ac_load_wins", ac, 16'h5555);
      idle(); clr_ac = 1'b1; cyc();
      check("ac_clear", ac, 16'h0000);

      // Illegal destination
      idle(); wr(4'b1100, 16'hDEAD); cyc();
      check("illegal_wr_done", {15'b0, wr_done}, 16'h0000);
      check("illegal_r2_kept", r2, 16'h1234);
      check("illegal_dest_err", {15'b0, dest_err}, {15'b0, ERR_EN});
      idle(); cyc(); cyc();
      check("dest_err_sticky", {15'b0, dest_err}, {15'b0, ERR_EN});

      // Simultaneous R1 write, AR increment and PC increment
      wr(4'b0111, 16'h00FF); cyc();
      idle(); wr(4'b0011, 16'h0001); inc_ar = 1'b1; inc_pc = 1'b1; cyc();
      check("multi_r1", r1, 16'h0001);
      check("multi_ar", ar, 16'h0100);
      check("multi_pc", pc, 16'h0041);

      // Reset overrides a concurrent write
      idle(); reset = 1'b1; wr(4'b0000, 16'h7777); cyc();
      check("reset_ra_write", ra, 16'h0000);
      check("reset_wr_done2", {15'b0, wr_done}, 16'h0000);
      check("reset_dest_err", {15'b0, dest_err}, 16'h0000);

      // Randomized run against the model
      for (int n = 0; n < 3000; n++) begin
         reset  = ($urandom_range(0, 59) == 0);
         wr_en  = ($urandom_range(0, 3) != 0);
         wr_sel = 4'($urandom_range(0, 15));
         bus_in = ($urandom_range(0, 7) == 0) ? 16'hFFFF : 16'($urandom);
         inc_pc = 1'($urandom_range(0, 1));
         inc_ar = 1'($urandom_range(0, 1));
         clr_ac = ($urandom_range(0, 3) == 0);
         cyc();
      end

      idle();
      cyc();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
